// File: rtl/uart_tx_param.sv
// UART transmitter with a write-side FIFO, a clock-derived baud prescaler and a
// runtime-selectable frame format (5-8 data bits, optional parity, 1/2 stop bits).
module uart_tx_param #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OVS        = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [7:0]                  data_in,
  input  logic                        write_en,
  input  logic                        tx_en,
  input  logic [1:0]                  data_len,
  input  logic                        parity_en,
  input  logic                        parity_type,
  input  logic                        stop2,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  tx_thr_val,
  output logic                        txd,
  output logic                        tx_busy,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        tx_thr,
  output logic                        wr_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = (OVS > 1) ? $clog2(OVS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, push, pop;
  logic          ovf_q, thr_q;
  logic [CW-1:0] thr_level;

  // Transmit engine
  state_e           state_q;
  logic             txd_q, busy_q;
  logic [DIV_W-1:0] presc_q;
  logic [OW-1:0]    ovs_q;
  logic [2:0]       bit_idx_q;
  logic             stop_idx_q;
  logic [7:0]       data_q;
  logic [1:0]       len_q;
  logic             par_en_q, par_odd_q, stop2_q;

  logic       tick, bit_end, can_start, frame_done, last_bit, par_bit;
  logic [2:0] next_idx;
  logic [7:0] len_mask;

  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign can_start  = tx_en && (count_q != '0);
  assign tick       = busy_q && (presc_q >= baud_div);
  assign bit_end    = tick && (ovs_q == OW'(OVS - 1));
  assign frame_done = (state_q == StStop) && bit_end && (stop_idx_q == stop2_q);
  // A new frame starts either from idle or straight out of the final stop bit.
  assign pop        = can_start && ((state_q == StIdle) || frame_done);
  assign push       = write_en && (!full || pop);

  assign next_idx = bit_idx_q + 3'd1;
  assign last_bit = (bit_idx_q == (3'd4 + {1'b0, len_q}));
  assign len_mask = 8'hFF >> (2'd3 - len_q);
  assign par_bit  = (^(data_q & len_mask)) ^ par_odd_q;

  always_comb begin
    thr_level = '0;
    case (tx_thr_val)
      2'b00:   thr_level = '0;
      2'b01:   thr_level = CW'(FIFO_DEPTH / 4);
      2'b10:   thr_level = CW'(FIFO_DEPTH / 2);
      default: thr_level = CW'((3 * FIFO_DEPTH) / 4);
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      thr_q    <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      ovf_q <= write_en && full && !pop;
      thr_q <= (count_q <= thr_level);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      presc_q    <= '0;
      ovs_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
    end else if (pop) begin
      // Format is captured here so mid-frame input changes cannot disturb the frame.
      state_q    <= StStart;
      txd_q      <= 1'b0;
      busy_q     <= 1'b1;
      presc_q    <= '0;
      ovs_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= mem_q[rd_ptr_q];
      len_q      <= data_len;
      par_en_q   <= parity_en;
      par_odd_q  <= parity_type;
      stop2_q    <= stop2;
    end else begin
      if (busy_q) begin
        if (tick) begin
          presc_q <= '0;
          ovs_q   <= (ovs_q == OW'(OVS - 1)) ? '0 : ovs_q + OW'(1);
        end else begin
          presc_q <= presc_q + DIV_W'(1);
        end
      end
      if (bit_end) begin
        case (state_q)
          StStart: begin
            state_q   <= StData;
            bit_idx_q <= '0;
            txd_q     <= data_q[0];
          end
          StData: begin
            if (!last_bit) begin
              bit_idx_q <= next_idx;
              txd_q     <= data_q[next_idx];
            end else if (par_en_q) begin
              state_q <= StParity;
              txd_q   <= par_bit;
            end else begin
              state_q    <= StStop;
              stop_idx_q <= 1'b0;
              txd_q      <= 1'b1;
            end
          end
          StParity: begin
            state_q    <= StStop;
            stop_idx_q <= 1'b0;
            txd_q      <= 1'b1;
          end
          StStop: begin
            if (stop_idx_q != stop2_q) begin
              stop_idx_q <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              txd_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            txd_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign txd         = txd_q;
  assign tx_busy     = busy_q;
  assign fifo_full   = full;
  assign fifo_empty  = (count_q == '0);
  assign fifo_count  = count_q;
  assign tx_thr      = thr_q;
  assign wr_overflow = ovf_q;

endmodule
